// File: rtl/movement_pkg.sv
// Shared state encoding and direction-word field positions for movement_stepper.
package movement_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP_X = 2'd1,
    S_STEP_Y = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // direction = {sign_x, mag_x[MAG_W-1:0], sign_y, mag_y[MAG_W-1:0]}
  function automatic int sign_x_pos(input int mag_w);
    return 2 * mag_w + 1;
  endfunction

  function automatic int mag_x_lsb(input int mag_w);
    return mag_w + 1;
  endfunction

  function automatic int sign_y_pos(input int mag_w);
    return mag_w;
  endfunction

endpackage

// File: rtl/movement_stepper_axis.sv
// Per-axis remaining-step down-counter with load, decrement and zero/last flags.
module movement_stepper_axis #(
  parameter int MAG_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [MAG_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  localparam logic [MAG_W-1:0] ONE = MAG_W'(1);

  logic [MAG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/movement_stepper.sv
// Direction word to interleaved X/Y unit-step pulse train, one move per accepted move_clk.
// Optional MOVEMENT_STEPPER_DROP_CNT_EN adds a saturating dropped-tick counter on drop_count.
//
// state    | meaning
// S_IDLE   | waiting for move_clk; latches magnitudes and signs on a tick
// S_STEP_X | issuing one X step per cycle (frozen while hold)
// S_STEP_Y | issuing one Y step per cycle (frozen while hold)
// S_DONE   | one-cycle done pulse, then back to S_IDLE
module movement_stepper
  import movement_pkg::*;
#(
  parameter  int MAG_W = 2,
  localparam int DIR_W = 2 * (MAG_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             move_clk,
  input  logic [DIR_W-1:0] direction,
  input  logic             hold,
  output logic             step_x,
  output logic             step_y,
  output logic             sign_x,
  output logic             sign_y,
  output logic             busy,
  output logic             done,
  output logic             dropped,
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
  output logic [7:0]       drop_count,
`endif
  output logic [1:0]       state
);

  localparam int SX  = sign_x_pos(MAG_W);
  localparam int MXL = mag_x_lsb(MAG_W);
  localparam int SY  = sign_y_pos(MAG_W);

  state_e state_q, state_d;
  logic   sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic   load, dec_x, dec_y;
  logic   x_zero, x_last, y_zero, y_last;

  logic [MAG_W-1:0] mag_x, mag_y;
  assign mag_x = direction[MXL +: MAG_W];
  assign mag_y = direction[0 +: MAG_W];

  movement_stepper_axis #(.MAG_W(MAG_W)) u_axis_x (
    .clk(clk), .reset_n(reset_n), .load_i(load), .load_val_i(mag_x),
    .dec_i(dec_x), .zero_o(x_zero), .last_o(x_last)
  );

  movement_stepper_axis #(.MAG_W(MAG_W)) u_axis_y (
    .clk(clk), .reset_n(reset_n), .load_i(load), .load_val_i(mag_y),
    .dec_i(dec_y), .zero_o(y_zero), .last_o(y_last)
  );

  always_comb begin
    state_d  = state_q;
    sign_x_d = sign_x_q;
    sign_y_d = sign_y_q;
    load     = 1'b0;
    dec_x    = 1'b0;
    dec_y    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (move_clk) begin
          load     = 1'b1;
          sign_x_d = direction[SX];
          sign_y_d = direction[SY];
          if (mag_x != '0)      state_d = S_STEP_X;
          else if (mag_y != '0) state_d = S_STEP_Y;
          else                  state_d = S_DONE;
        end
      end
      // Counter is non-zero here, so "last" means it reaches zero after this step.
      S_STEP_X: begin
        if (!hold) begin
          dec_x = 1'b1;
          if (!y_zero)      state_d = S_STEP_Y;
          else if (!x_last) state_d = S_STEP_X;
          else              state_d = S_DONE;
        end
      end
      S_STEP_Y: begin
        if (!hold) begin
          dec_y = 1'b1;
          if (!x_zero)      state_d = S_STEP_X;
          else if (!y_last) state_d = S_STEP_Y;
          else              state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q  <= S_IDLE;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_x_q <= sign_x_d;
      sign_y_q <= sign_y_d;
    end
  end

  assign step_x  = (state_q == S_STEP_X) && !hold;
  assign step_y  = (state_q == S_STEP_Y) && !hold;
  assign busy    = (state_q == S_STEP_X) || (state_q == S_STEP_Y);
  assign done    = (state_q == S_DONE);
  assign dropped = move_clk && (state_q != S_IDLE);
  assign sign_x  = sign_x_q;
  assign sign_y  = sign_y_q;
  assign state   = state_q;

`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = (dropped && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) drop_cnt_q <= 8'd0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_movement_stepper.sv
// Directed bench for movement_stepper: MAG_W=2 instance for most steps, MAG_W=4 for hold/saturation.
module tb_movement_stepper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       move_clk = 1'b0, hold = 1'b0;
  logic [5:0] direction = '0;
  logic       step_x, step_y, sign_x, sign_y, busy, done, dropped;
  logic [1:0] state;

  logic       move_clk4 = 1'b0, hold4 = 1'b0;
  logic [9:0] direction4 = '0;
  logic       step_x4, step_y4, sign_x4, sign_y4, busy4, done4, dropped4;
  logic [1:0] state4;
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
  logic [7:0] drop_count, drop_count4;
`endif

  int vectors = 0;
  int miscompares = 0;
  int nsteps;
  logic [3:0] px, py;

  always #5 clk = ~clk;

  movement_stepper #(.MAG_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .move_clk(move_clk), .direction(direction), .hold(hold),
    .step_x(step_x), .step_y(step_y), .sign_x(sign_x), .sign_y(sign_y),
    .busy(busy), .done(done), .dropped(dropped),
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .state(state)
  );

  movement_stepper #(.MAG_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .move_clk(move_clk4), .direction(direction4), .hold(hold4),
    .step_x(step_x4), .step_y(step_y4), .sign_x(sign_x4), .sign_y(sign_y4),
    .busy(busy4), .done(done4), .dropped(dropped4),
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
    .drop_count(drop_count4),
`endif
    .state(state4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_steps", 32'({step_x, step_y}), 0);
    chk("rst_flags", 32'({busy, done, dropped, sign_x, sign_y}), 0);
    chk("rst_state4", 32'(state4), 0);
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
    chk("rst_drop_count", 32'(drop_count), 0);
`endif
    reset_n = 1'b0;
    step();

    // Interleave: x=-3, y=+1 -> X,Y,X,X then done
    direction = 6'b1_11_0_01;
    move_clk  = 1'b1;
    #1 chk("ilv_no_drop_idle", 32'(dropped), 0);
    step();
    move_clk  = 1'b0;
    px = 4'b1101;
    py = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) direction = 6'b0;
      chk($sformatf("ilv_step_x_%0d", i), 32'(step_x), 32'(px[i]));
      chk($sformatf("ilv_step_y_%0d", i), 32'(step_y), 32'(py[i]));
      chk($sformatf("ilv_busy_%0d", i), 32'(busy), 1);
      step();
    end
    chk("ilv_done", 32'(done), 1);
    chk("ilv_done_state", 32'(state), 3);
    chk("ilv_signs", 32'({sign_x, sign_y}), 32'(2'b10));
    step();
    chk("ilv_idle", 32'({state, done}), 0);
    chk("ilv_sign_kept", 32'({sign_x, sign_y}), 32'(2'b10));

    // Zero move
    direction = 6'b0_00_1_00;
    move_clk  = 1'b1;
    step();
    move_clk  = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_no_steps_busy", 32'({step_x, step_y, busy}), 0);
    chk("zero_signs", 32'({sign_x, sign_y}), 32'(2'b01));
    step();
    chk("zero_idle", 32'({state, done, busy}), 0);

    // Dropped tick: x=2, y=2, second tick two cycles later
    direction = 6'b0_10_0_10;
    move_clk  = 1'b1;
    step();
    move_clk  = 1'b0;
    nsteps = int'(step_x) + int'(step_y);
    step();
    move_clk  = 1'b1;
    direction = 6'b0_11_0_11;
    #1;
    chk("drop_pulse", 32'(dropped), 1);
    chk("drop_state", 32'(state), 2);
    nsteps += int'(step_x) + int'(step_y);
    step();
    move_clk = 1'b0;
    #1 chk("drop_one_cycle", 32'(dropped), 0);
    for (int i = 0; i < 2; i++) begin
      nsteps += int'(step_x) + int'(step_y);
      step();
    end
    chk("drop_done_n5", 32'(done), 1);
    chk("drop_total_steps", 32'(nsteps), 4);
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
    chk("drop_count_one", 32'(drop_count), 1);
`endif
    step();

    // Reset mid-move: x=-3, y=-3, reset after second step
    direction = 6'b1_11_1_11;
    move_clk  = 1'b1;
    step();
    move_clk  = 1'b0;
    chk("rmm_step1", 32'({step_x, step_y}), 32'(2'b10));
    step();
    chk("rmm_step2", 32'({step_x, step_y}), 32'(2'b01));
    reset_n = 1'b1;
    #1;
    chk("rmm_state", 32'(state), 0);
    chk("rmm_outputs", 32'({step_x, step_y, busy, done, dropped, sign_x, sign_y}), 0);
    step(); step();
    reset_n = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 6; i++) begin
      nsteps += int'(step_x) + int'(step_y);
      step();
    end
    chk("rmm_no_more_steps", 32'(nsteps), 0);
    chk("rmm_idle", 32'({state, busy, done}), 0);
`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
    chk("rmm_drop_count_cleared", 32'(drop_count), 0);
`endif

    // Hold on MAG_W=4: x=5, y=0, hold 3 cycles after second step
    direction4 = {1'b0, 4'd5, 1'b0, 4'd0};
    move_clk4  = 1'b1;
    step();
    move_clk4  = 1'b0;
    nsteps = int'(step_x4);
    step();
    nsteps += int'(step_x4);
    chk("hold_pre_steps", 32'(nsteps), 2);
    step();
    hold4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_frozen_%0d", i), 32'({step_x4, step_y4, busy4}), 32'(3'b001));
      chk($sformatf("hold_state_%0d", i), 32'(state4), 1);
      step();
    end
    hold4 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_resume_%0d", i), 32'({step_x4, busy4, done4}), 32'(3'b110));
      nsteps += int'(step_x4);
      step();
    end
    chk("hold_total_steps", 32'(nsteps), 5);
    chk("hold_done", 32'({done4, busy4}), 32'(2'b10));
    step();
    chk("hold_idle", 32'(state4), 0);

`ifdef MOVEMENT_STEPPER_DROP_CNT_EN
    // Saturation: continuous ticks during back-to-back 30-step moves
    direction4 = {1'b0, 4'd15, 1'b0, 4'd15};
    move_clk4  = 1'b1;
    repeat (400) step();
    move_clk4  = 1'b0;
    repeat (40) step();
    chk("sat_drop_count", 32'(drop_count4), 255);
    chk("sat_idle", 32'(state4), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
